// File: rtl/instr_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : instr_sequencer_if
// Description : Instruction-memory and datapath control bundle of the sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_sequencer_if #(
  parameter int PC_W = 8,
  parameter int IW   = 18
);
  logic [PC_W-1:0] imem_addr;
  logic [IW-1:0]   imem_data;
  logic [7:0]      result;
  logic            ovf;
  logic            take_branch;
  logic            RegWrite;
  logic [1:0]      ReadAddr1;
  logic [1:0]      ReadAddr2;
  logic [1:0]      WriteAddr;
  logic [8:0]      WriteData;
  logic [7:0]      Instr_i;
  logic            ALUSrc1;
  logic            ALUSrc2;
  logic [2:0]      ALUOp;

  modport master (
    output imem_addr,
    input  imem_data,
    input  result,
    input  ovf,
    input  take_branch,
    output RegWrite,
    output ReadAddr1,
    output ReadAddr2,
    output WriteAddr,
    output WriteData,
    output Instr_i,
    output ALUSrc1,
    output ALUSrc2,
    output ALUOp
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output result,
    output ovf,
    output take_branch,
    input  RegWrite,
    input  ReadAddr1,
    input  ReadAddr2,
    input  WriteAddr,
    input  WriteData,
    input  Instr_i,
    input  ALUSrc1,
    input  ALUSrc2,
    input  ALUOp
  );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer.sv
//------------------------------------------------------------------------------
// Module      : instr_sequencer
// Description : Three-cycle fetch/decode/execute control stage driving the ALU datapath.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_sequencer #(
  parameter int PC_W = 8,
  parameter int IW   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  instr_sequencer_if.master      bus,
  output logic [PC_W-1:0]        pc,
  output logic                   halted
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [1:0] CLS_R  = 2'b00;
  localparam logic [1:0] CLS_I  = 2'b01;
  localparam logic [1:0] CLS_LI = 2'b10;
  localparam logic [1:0] CLS_BR = 2'b11;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [IW-1:0]   ir;
  logic [1:0]      cls;
  logic            halt_bit;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;

  assign cls      = ir[17:16];
  assign halt_bit = ir[8];
  assign pc_inc   = pc + PC_W'(1);
  // Size cast of a signed operand sign-extends the 8-bit offset to PC_W.
  assign pc_br    = pc_inc + PC_W'($signed(ir[7:0]));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = halt_bit ? ST_HALT : ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (state == ST_DECODE) begin
        ir <= bus.imem_data;
      end
      if ((state == ST_EXEC) && !halt_bit) begin
        pc <= ((cls == CLS_BR) && bus.take_branch) ? pc_br : pc_inc;
      end
    end
  end

  // RegWrite is gated by rst so an aborted instruction never reaches the register file.
  always_comb begin
    bus.imem_addr = pc;
    bus.RegWrite  = (state == ST_EXEC) && !rst && !halt_bit && (cls != CLS_BR);
    bus.ReadAddr1 = ir[12:11];
    bus.ReadAddr2 = ir[10:9];
    bus.WriteAddr = ir[12:11];
    bus.WriteData = {bus.ovf, bus.result};
    bus.Instr_i   = ir[7:0];
    bus.ALUOp     = ir[15:13];
    bus.ALUSrc1   = (cls == CLS_LI);
    bus.ALUSrc2   = (cls == CLS_I) || (cls == CLS_LI);
    halted        = (state == ST_HALT);
  end

endmodule

`default_nettype wire
